mul_share_arb: RTL and testbench

Round-robin arbiter/sequencer sharing one start/ready sequential multiplier (24x24->48) among N_REQ requesters. Accepts one operand pair at a time, issues it to the multiplier, waits for completion, returns the product to the owning requester with backpressure. Sits between client datapaths and the single multiplier instance.

---
 rtl/mul_share_pkg.sv | 7 +
 rtl/rr_pick.sv | 26 ++
 rtl/mul_share_arb.sv | 86 ++++++++
 tb/tb_mul_share_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared FSM states and default sizing for the multiplier arbiter.
package mul_share_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 24;
  localparam int TIMEOUT_CYC_DEF = 64;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, scans from ptr+1 modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    j = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one start/ready multiplier among N_REQ requesters.
// Optional watchdog on the multiplier wait enabled by MUL_SHARE_TIMEOUT_EN.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   rsp_err,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_ready,
  input  logic [2*WIDTH-1:0]     mul_result
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state, nxt;
  logic [IW-1:0] ptr, owner, win_idx;
  logic [N_REQ-1:0] grant;
  logic any, tmo;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(win_idx),
    .any(any)
  );
`ifdef MUL_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign tmo = (state == WAIT) && !mul_ready && (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == WAIT && mul_ready) rsp_err <= 1'b0;
      else if (tmo) rsp_err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (mul_ready || tmo) ? RESP : WAIT;
      default: nxt = rsp_ready[owner] ? IDLE : RESP;
    endcase
  end
  assign req_ready = (state == IDLE) ? grant : '0;
  assign mul_start = (state == ISSUE);
  assign rsp_valid = (state == RESP) ? N_REQ'(1) << owner : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(N_REQ - 1);
      owner <= '0;
      mul_a <= '0;
      mul_b <= '0;
      rsp_data <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        mul_a <= req_a[int'(win_idx)*WIDTH +: WIDTH];
        mul_b <= req_b[int'(win_idx)*WIDTH +: WIDTH];
        owner <= win_idx;
        ptr <= win_idx;
      end
      if (state == WAIT && mul_ready) rsp_data <= mul_result;
      else if (tmo) rsp_data <= '0;
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed and randomized checks of the shared multiplier arbiter.
module tb_mul_share_arb;
  localparam int N = 4;
  localparam int W = 24;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [2*W-1:0] rsp_data, mul_result;
  logic rsp_err, mul_start, mul_ready;
  logic [W-1:0] mul_a, mul_b;
  logic [W-1:0] a[N], b[N];
  int tests = 0, fails = 0, last, idx, n;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
  mul_share_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_result(mul_result)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int rr(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic serve(input int id, input int lat, input int hold, input bit drop);
    logic [2*W-1:0] exp_p;
    int m = 0;
    exp_p = 48'(a[id]) * 48'(b[id]);
    #1;
    while (req_ready === '0 && m < 50) begin
      @(negedge clk);
      m++;
    end
    chk("accept", 64'(req_ready), 64'(N'(1) << id));
    last = id;
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
    chk("start", 64'(mul_start), 1);
    chk("mul_a", 64'(mul_a), 64'(a[id]));
    chk("mul_b", 64'(mul_b), 64'(b[id]));
    chk("busy_ready", 64'(req_ready), 0);
    repeat (lat) begin
      @(negedge clk);
      chk("start_once", 64'(mul_start), 0);
    end
    mul_ready = 1'b1;
    mul_result = 48'(mul_a) * 48'(mul_b);
    @(negedge clk);
    mul_ready = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << id));
    chk("rsp_data", 64'(rsp_data), 64'(exp_p));
    chk("rsp_err", 64'(rsp_err), 0);
    rsp_ready = ~(N'(1) << id);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(N'(1) << id));
      chk("hold_data", 64'(rsp_data), 64'(exp_p));
      chk("hold_ready", 64'(req_ready), 0);
      chk("hold_start", 64'(mul_start), 0);
    end
    rsp_ready = N'(1) << id;
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_drop", 64'(rsp_valid), 0);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    mul_ready = 1'b0;
    mul_result = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    last = N - 1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_data", 64'(rsp_data), 0);
    chk("rst_start", 64'(mul_start), 0);
    chk("rst_mul_a", 64'(mul_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      a[i] = W'(i + 1);
      b[i] = 24'd7;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) serve(k % N, 3, 0, 1'b0);
    req_valid = '0;
    a[0] = 24'd3;
    b[0] = 24'd5;
    req_valid = 4'b0001;
    serve(0, 24, 0, 1'b1);
    mul_ready = 1'b1;
    mul_result = 48'h123;
    @(negedge clk);
    mul_ready = 1'b0;
    chk("stray_valid", 64'(rsp_valid), 0);
    chk("stray_start", 64'(mul_start), 0);
    @(negedge clk);
    chk("stray_data", 64'(rsp_data), 15);
    a[1] = 24'd11;
    b[1] = 24'd13;
    req_valid = '1;
    serve(rr(req_valid), 4, 10, 1'b1);
    req_valid = '0;
    a[3] = 24'hFFFFFF;
    b[3] = 24'hFFFFFF;
    req_valid = 4'b1000;
    serve(3, 2, 0, 1'b1);
    chk("max_data", 64'(rsp_data), 64'h0000FFFFFE000001);
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = W'($urandom);
        b[i] = W'($urandom);
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      idx = rr(req_valid);
      serve(idx, $urandom_range(1, 6), $urandom_range(0, 3), 1'b1);
    end
    req_valid = '0;
`ifdef MUL_SHARE_TIMEOUT_EN
    a[2] = 24'd9;
    b[2] = 24'd9;
    req_valid = 4'b0100;
    #1;
    chk("to_accept", 64'(req_ready), 4);
    last = 2;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (rsp_valid === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 64'(n), 65);
    chk("to_valid", 64'(rsp_valid), 4);
    chk("to_err", 64'(rsp_err), 1);
    chk("to_data", 64'(rsp_data), 0);
    mul_ready = 1'b1;
    mul_result = 48'h55;
    @(negedge clk);
    mul_ready = 1'b0;
    chk("to_late_data", 64'(rsp_data), 0);
    chk("to_late_err", 64'(rsp_err), 1);
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 4'b0100;
    serve(2, 3, 0, 1'b1);
    req_valid = '0;
`endif
    a[1] = 24'd2;
    b[1] = 24'd4;
    req_valid = 4'b0010;
    #1;
    chk("rw_accept", 64'(req_ready), 2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_req_ready", 64'(req_ready), 0);
    chk("rw_rsp_valid", 64'(rsp_valid), 0);
    chk("rw_rsp_data", 64'(rsp_data), 0);
    chk("rw_rsp_err", 64'(rsp_err), 0);
    chk("rw_start", 64'(mul_start), 0);
    chk("rw_mul_a", 64'(mul_a), 0);
    chk("rw_mul_b", 64'(mul_b), 0);
    @(negedge clk);
    rst = 1'b0;
    last = N - 1;
    a[0] = 24'd6;
    b[0] = 24'd6;
    a[2] = 24'd8;
    b[2] = 24'd8;
    req_valid = 4'b0101;
    serve(rr(req_valid), 2, 0, 1'b1);
    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
